// File: rtl/decoder_scan_ctrl_pkg.sv
// Shared definitions for the decoder scan controller and its decoder bench.
package decoder_scan_ctrl_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned SEL_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_ON    = 2'd2,
        ST_GAP   = 2'd3
    } scan_state_e;

endpackage

// File: rtl/decoder_scan_next.sv
// Combinational channel picker: next set mask bit above cur (with wrap) and lowest set bit.
module decoder_scan_next
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [SEL_W-1:0]  cur_i,
    output logic [SEL_W-1:0]  next_o,
    output logic              wrapped_o,
    output logic [SEL_W-1:0]  lowest_o
);

    // Search upward from cur+1; a distance that passes the top index means a wrap.
    always_comb begin
        logic        found;
        int unsigned pos;
        int unsigned idx;
        found     = 1'b0;
        next_o    = cur_i;
        wrapped_o = 1'b0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            pos = int'(cur_i) + i;
            idx = pos % NUM_CH;
            if (!found && mask_i[idx]) begin
                found     = 1'b1;
                next_o    = SEL_W'(idx);
                wrapped_o = (pos >= NUM_CH);
            end
        end
    end

    // Lowest set bit: scan downward so the last hit is the smallest index.
    always_comb begin
        lowest_o = '0;
        for (int unsigned i = NUM_CH; i > 0; i--) begin
            if (mask_i[i-1]) lowest_o = SEL_W'(i-1);
        end
    end

endmodule

// File: rtl/decoder_scan_ctrl.sv
// Scan controller driving the S/Enable inputs of a 3-to-8 decoder.
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic               oneshot,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   S,
    output logic               Enable,
    output logic               busy,
    output logic               ch_strobe,
    output logic               frame_done
);

    localparam int GAP_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    scan_state_e        state_q, state_d;
    logic [SEL_W-1:0]   s_q, s_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;
    logic               strobe_q, strobe_d;
    logic               fd_q, fd_d;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               oneshot_q, oneshot_d;
    logic [DWELL_W-1:0] dcnt_q, dcnt_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;

    logic [SEL_W-1:0]   next_ch;
    logic               next_wrap;
    logic [SEL_W-1:0]   lowest_ch;
    logic               advance;

    decoder_scan_next u_next (
        .mask_i    (mask_q),
        .cur_i     (s_q),
        .next_o    (next_ch),
        .wrapped_o (next_wrap),
        .lowest_o  ()
    );

    decoder_scan_next u_first (
        .mask_i    (ch_mask),
        .cur_i     ('0),
        .next_o    (),
        .wrapped_o (),
        .lowest_o  (lowest_ch)
    );

    // Next-state and registered-output values; stop overrides everything while busy.
    // With BLANK_CYCLES=0 the ON->SETUP edge both drops Enable and loads the next S.
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        en_d      = 1'b0;
        busy_d    = busy_q;
        strobe_d  = 1'b0;
        fd_d      = 1'b0;
        mask_d    = mask_q;
        dwell_d   = dwell_q;
        oneshot_d = oneshot_q;
        dcnt_d    = dcnt_q;
        gcnt_d    = gcnt_q;
        advance   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (ch_mask != '0)) begin
                    state_d   = ST_SETUP;
                    s_d       = lowest_ch;
                    busy_d    = 1'b1;
                    mask_d    = ch_mask;
                    dwell_d   = dwell;
                    oneshot_d = oneshot;
                end
            end
            ST_SETUP: begin
                state_d  = ST_ON;
                en_d     = 1'b1;
                strobe_d = 1'b1;
                dcnt_d   = (dwell_q == '0) ? DWELL_W'(1) : dwell_q;
            end
            ST_ON: begin
                if (dcnt_q > DWELL_W'(1)) begin
                    dcnt_d = dcnt_q - DWELL_W'(1);
                    en_d   = 1'b1;
                end else if (BLANK_CYCLES > 0) begin
                    state_d = ST_GAP;
                    gcnt_d  = GAP_W'(BLANK_CYCLES);
                end else begin
                    advance = 1'b1;
                end
            end
            ST_GAP: begin
                if (gcnt_q > GAP_W'(1)) gcnt_d = gcnt_q - GAP_W'(1);
                else                    advance = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            fd_d = next_wrap;
            if (next_wrap && oneshot_q) begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end else begin
                state_d = ST_SETUP;
                s_d     = next_ch;
            end
        end

        if (stop && busy_q) begin
            state_d  = ST_IDLE;
            s_d      = s_q;
            en_d     = 1'b0;
            busy_d   = 1'b0;
            strobe_d = 1'b0;
            fd_d     = 1'b0;
        end
    end

    // State, outputs and latched configuration; synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            strobe_q  <= 1'b0;
            fd_q      <= 1'b0;
            mask_q    <= '0;
            dwell_q   <= '0;
            oneshot_q <= 1'b0;
            dcnt_q    <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            strobe_q  <= strobe_d;
            fd_q      <= fd_d;
            mask_q    <= mask_d;
            dwell_q   <= dwell_d;
            oneshot_q <= oneshot_d;
            dcnt_q    <= dcnt_d;
            gcnt_q    <= gcnt_d;
        end
    end

    assign S          = s_q;
    assign Enable     = en_q;
    assign busy       = busy_q;
    assign ch_strobe  = strobe_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench: per-cycle vector table for scan sequences plus hand-written corner cases.
module tb_decoder_scan_ctrl;
    import decoder_scan_ctrl_pkg::*;

    localparam logic [7:0] M = 8'b0010_0101;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop, oneshot;
    logic [7:0]  ch_mask;
    logic [15:0] dwell;
    logic [2:0]  S;
    logic        Enable, busy, ch_strobe, frame_done;

    logic        start0, stop0;
    logic [7:0]  ch_mask0;
    logic [15:0] dwell0;
    logic [2:0]  S0;
    logic        Enable0, busy0, ch_strobe0, frame_done0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       st, sp, os;
        logic [7:0] mask;
        logic [15:0] dw;
        logic [2:0] s;
        logic       en, bz, sb, fd;
    } vec_t;

    vec_t vecs[$];

    decoder_scan_ctrl #(.DWELL_W(16), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot),
        .ch_mask(ch_mask), .dwell(dwell), .S(S), .Enable(Enable), .busy(busy),
        .ch_strobe(ch_strobe), .frame_done(frame_done)
    );

    decoder_scan_ctrl #(.DWELL_W(16), .BLANK_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .stop(stop0), .oneshot(1'b0),
        .ch_mask(ch_mask0), .dwell(dwell0), .S(S0), .Enable(Enable0), .busy(busy0),
        .ch_strobe(ch_strobe0), .frame_done(frame_done0)
    );

    always #5 clk = ~clk;

    // Watch the glitch-free property on the BLANK=2 instance.
    logic [2:0] s_prev;
    logic       en_prev;
    always @(posedge clk) begin
        s_prev  <= S;
        en_prev <= Enable;
    end
    always @(negedge clk) begin
        if (!rst && (S != s_prev) && (Enable || en_prev)) begin
            failures++;
            $display("FAIL glitch: S %0d->%0d with Enable prev=%0b now=%0b", s_prev, S, en_prev, Enable);
        end
    end

    task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got {S,en,busy,strb,fd}=%b want %b", name, act, exp);
        end
    endtask

    task automatic add(input logic st, sp, os, input logic [7:0] mk, input logic [15:0] dw,
                       input logic [2:0] s, input logic en, bz, sb, fd);
        vec_t v;
        v.st = st; v.sp = sp; v.os = os; v.mask = mk; v.dw = dw;
        v.s = s; v.en = en; v.bz = bz; v.sb = sb; v.fd = fd;
        vecs.push_back(v);
    endtask

    // One channel of dwell=3, BLANK=2: SETUP, 3 ON (strobe on first), 2 GAP.
    task automatic add_channel(input logic st, os, input logic [2:0] s, input logic fd);
        add(st, 0, os, M, 16'd3, s, 0, 1, 0, fd);
        add(0, 0, 0, M, 16'd3, s, 1, 1, 1, 0);
        add(0, 0, 0, M, 16'd3, s, 1, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, s, 1, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, s, 0, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, s, 0, 1, 0, 0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; start = 0; stop = 0; oneshot = 0; ch_mask = '0; dwell = '0;
        start0 = 0; stop0 = 0; ch_mask0 = '0; dwell0 = '0;

        // Continuous frame, then stop in GAP, start+stop together, start with empty mask.
        add_channel(1, 0, 3'd0, 0);
        add_channel(0, 0, 3'd2, 0);
        add_channel(0, 0, 3'd5, 0);
        add_channel(0, 0, 3'd0, 1);
        add(0, 1, 0, M, 16'd3, 3'd0, 0, 0, 0, 0);
        add(1, 1, 0, M, 16'd3, 3'd0, 0, 0, 0, 0);
        add(1, 0, 0, 8'h00, 16'd3, 3'd0, 0, 0, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 0, 0, 0, 0);
        // One-shot frame ends in IDLE with S on the last channel.
        add_channel(1, 1, 3'd0, 0);
        add_channel(0, 0, 3'd2, 0);
        add_channel(0, 0, 3'd5, 0);
        add(0, 0, 0, M, 16'd3, 3'd5, 0, 0, 0, 1);
        add(0, 0, 0, M, 16'd3, 3'd5, 0, 0, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd5, 0, 0, 0, 0);
        // Start while busy is ignored; stop during ON of channel 2.
        add(1, 0, 0, M, 16'd3, 3'd0, 0, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 1, 1, 1, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 1, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 1, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 0, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd0, 0, 1, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd2, 0, 1, 0, 0);
        add(1, 0, 1, 8'h80, 16'd1, 3'd2, 1, 1, 1, 0);
        add(0, 0, 0, M, 16'd3, 3'd2, 1, 1, 0, 0);
        add(0, 1, 0, M, 16'd3, 3'd2, 0, 0, 0, 0);
        add(0, 0, 0, M, 16'd3, 3'd2, 0, 0, 0, 0);

        step; step;
        chk("reset", {S, Enable, busy, ch_strobe, frame_done}, 7'b000_0000);
        chk("reset0", {S0, Enable0, busy0, ch_strobe0, frame_done0}, 7'b000_0000);
        rst = 0;
        step;
        chk("idle", {S, Enable, busy, ch_strobe, frame_done}, 7'b000_0000);

        for (int i = 0; i < vecs.size(); i++) begin
            start = vecs[i].st; stop = vecs[i].sp; oneshot = vecs[i].os;
            ch_mask = vecs[i].mask; dwell = vecs[i].dw;
            step;
            chk($sformatf("vec%0d", i), {S, Enable, busy, ch_strobe, frame_done},
                {vecs[i].s, vecs[i].en, vecs[i].bz, vecs[i].sb, vecs[i].fd});
        end
        start = 0; stop = 0; oneshot = 0;

        // Reset held 3 cycles during ON.
        start = 1; ch_mask = M; dwell = 16'd3;
        step;
        start = 0;
        step;
        chk("pre_rst_on", {S, Enable, busy, ch_strobe, frame_done}, 7'b000_1110);
        step;
        rst = 1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk($sformatf("rst_on%0d", i), {S, Enable, busy, ch_strobe, frame_done}, 7'b000_0000);
        end
        rst = 0;
        step;
        chk("post_rst", {S, Enable, busy, ch_strobe, frame_done}, 7'b000_0000);

        // BLANK=0, dwell=0, single channel 7: Enable toggles every cycle.
        start0 = 1; ch_mask0 = 8'h80; dwell0 = 16'd0;
        step;
        start0 = 0;
        chk("b0_setup", {S0, Enable0, busy0, ch_strobe0, frame_done0}, 7'b111_0100);
        for (int i = 0; i < 6; i++) begin
            step;
            if (i % 2 == 0)
                chk($sformatf("b0_on%0d", i), {S0, Enable0, busy0, ch_strobe0, frame_done0}, 7'b111_1110);
            else
                chk($sformatf("b0_set%0d", i), {S0, Enable0, busy0, ch_strobe0, frame_done0}, 7'b111_0101);
        end
        stop0 = 1;
        step;
        stop0 = 0;
        chk("b0_stop", {S0, Enable0, busy0, ch_strobe0, frame_done0}, 7'b111_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
